// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle RV32 subset datapath.
// It sequences fetch, decode, execute, memory and write-back and drives the datapath enables and selects.
`default_nettype none

module multicycle_control #(
   parameter int DATA_BUS = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_BUS-1:0] instr,
   input  logic                Zero,
   input  logic                mem_ready,
   output logic [2:0]          ImmSrc,
   output logic                PCWrite,
   output logic                IRWrite,
   output logic                RegWrite,
   output logic                MemRead,
   output logic                MemWrite,
   output logic [1:0]          ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          ResultSrc,
   output logic                illegal,
   output logic [2:0]          state
);

   // instr_format encoding of ImmSrc
   localparam logic [2:0] c_IMM_I     = 3'd0;
   localparam logic [2:0] c_IMM_STORE = 3'd1;
   localparam logic [2:0] c_IMM_BR    = 3'd2;
   localparam logic [2:0] c_IMM_JUMP  = 3'd3;
   localparam logic [2:0] c_IMM_UPPER = 3'd4;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_LUI, OP_BAD
   } op_t;

   state_t     r_state, w_next;
   logic [2:0] r_imm_src;
   logic       r_illegal;
   logic       r_run;
   op_t        w_op;
   logic [2:0] w_imm_dec;
   logic       w_taken;
   logic       w_unused;

   assign w_unused = ^{instr[DATA_BUS-1:15], instr[11:7]};

   always_comb begin
      w_op      = OP_BAD;
      w_imm_dec = c_IMM_I;
      case (instr[6:0])
         7'b0110011: w_op = OP_R;
         7'b0010011: w_op = OP_I;
         7'b0000011: w_op = OP_LW;
         7'b0100011: begin w_op = OP_SW;  w_imm_dec = c_IMM_STORE; end
         7'b1100011: begin w_op = OP_BR;  w_imm_dec = c_IMM_BR;    end
         7'b1101111: begin w_op = OP_JAL; w_imm_dec = c_IMM_JUMP;  end
         7'b0110111: begin w_op = OP_LUI; w_imm_dec = c_IMM_UPPER; end
         default:    w_op = OP_BAD;
      endcase
   end

   assign w_taken = ((instr[14:12] == 3'b000) &&  Zero) ||
                    ((instr[14:12] == 3'b001) && !Zero);

   // r_run stays low for the first edge after reset so the first fetch starts on that edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FETCH;
         r_imm_src <= c_IMM_I;
         r_illegal <= 1'b0;
         r_run     <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (r_run) begin
            r_state <= w_next;
            if (r_state == DECODE) begin
               if (w_op == OP_BAD) r_illegal <= 1'b1;
               else                r_imm_src <= w_imm_dec;
            end
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      ALUSrcA   = 2'd0;
      ALUSrcB   = 2'd0;
      ResultSrc = 2'd0;
      if (r_run && !rst) begin
         case (r_state)
            FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'd2;
               if (mem_ready) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  w_next  = DECODE;
               end
            end
            DECODE: w_next = (w_op == OP_BAD) ? FETCH : EXEC;
            EXEC: begin
               case (w_op)
                  OP_R:          begin ALUSrcA = 2'd1; w_next = WB; end
                  OP_I:          begin ALUSrcA = 2'd1; ALUSrcB = 2'd1; w_next = WB;  end
                  OP_LW, OP_SW:  begin ALUSrcA = 2'd1; ALUSrcB = 2'd1; w_next = MEM; end
                  OP_LUI:        begin ALUSrcA = 2'd2; ALUSrcB = 2'd1; w_next = WB;  end
                  OP_BR: begin
                     ALUSrcA = 2'd1;
                     PCWrite = w_taken;
                     w_next  = FETCH;
                  end
                  OP_JAL: begin
                     ALUSrcB = 2'd1;
                     PCWrite = 1'b1;
                     w_next  = WB;
                  end
                  default: w_next = FETCH;
               endcase
            end
            MEM: begin
               if (w_op == OP_LW) begin
                  MemRead = 1'b1;
                  if (mem_ready) w_next = WB;
               end else if (w_op == OP_SW) begin
                  MemWrite = 1'b1;
                  if (mem_ready) w_next = FETCH;
               end else begin
                  w_next = FETCH;
               end
            end
            WB: begin
               RegWrite  = 1'b1;
               ResultSrc = (w_op == OP_LW)  ? 2'd1 :
                           (w_op == OP_JAL) ? 2'd2 : 2'd0;
               w_next    = FETCH;
            end
            default: w_next = FETCH;
         endcase
      end
   end

   assign ImmSrc  = r_imm_src;
   assign illegal = r_illegal;
   assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench driving directed instruction sequences into multicycle_control.
`default_nettype none

module tb_multicycle_control;

   typedef struct packed {
      logic [2:0] st;
      logic       pcw, irw, rw, mr, mw;
      logic [1:0] a, b, rs;
      logic [2:0] imm;
      logic       ill;
   } exp_t;

   logic        clk = 1'b1;
   logic        rst;
   logic [31:0] instr;
   logic        Zero, mem_ready;
   logic [2:0]  ImmSrc, state;
   logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, illegal;
   logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   event ev_async;

   multicycle_control #(.DATA_BUS(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
      .ImmSrc(ImmSrc), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(int st, int pcw, int irw, int rw, int mr, int mw,
                               int a, int b, int rs, int imm, int ill);
      exp_t e;
      e.st = 3'(st); e.pcw = 1'(pcw); e.irw = 1'(irw); e.rw = 1'(rw);
      e.mr = 1'(mr); e.mw = 1'(mw); e.a = 2'(a); e.b = 2'(b); e.rs = 2'(rs);
      e.imm = 3'(imm); e.ill = 1'(ill);
      return e;
   endfunction

   // Monitor: the control outputs are valid every cycle, sampled on the falling edge
   always begin
      exp_t e, act;
      @(negedge clk or ev_async);
      act = {state, PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, illegal};
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_total++;
         if (act === e) n_pass++;
         else $display("FAIL ctrl t=%0t actual=%h required=%h (st pcw irw rw mr mw a b rs imm ill)",
                       $time, act, e);
      end
      n_total++;
      if (!(MemRead && MemWrite) && ($countones({PCWrite, RegWrite, MemWrite}) <= 1)) n_pass++;
      else $display("FAIL excl t=%0t actual pcw/rw/mr/mw=%b%b%b%b required at most one write, no rd+wr",
                    $time, PCWrite, RegWrite, MemRead, MemWrite);
   end

   task automatic cyc(input logic r, input logic mr, input logic z,
                      input logic [31:0] ins, input exp_t e);
      rst = r; mem_ready = mr; Zero = z; instr = ins;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] c_R   = 32'h002081B3;
   localparam logic [31:0] c_LW  = 32'h0040A183;
   localparam logic [31:0] c_BEQ = 32'h00208463;
   localparam logic [31:0] c_SW  = 32'h0020A223;
   localparam logic [31:0] c_JAL = 32'h0000006F;
   localparam logic [31:0] c_LUI = 32'h000000B7;
   localparam logic [31:0] c_BAD = 32'h0000007F;

   initial begin
      #1;
      cyc(1, 1, 0, c_R, mk(0,0,0,0,0,0, 0,0,0, 0,0));
      cyc(0, 1, 0, c_R, mk(0,0,0,0,0,0, 0,0,0, 0,0));
      // R-type
      cyc(0, 1, 0, c_R, mk(0,1,1,0,1,0, 0,2,0, 0,0));
      cyc(0, 1, 0, c_R, mk(1,0,0,0,0,0, 0,0,0, 0,0));
      cyc(0, 1, 0, c_R, mk(2,0,0,0,0,0, 1,0,0, 0,0));
      cyc(0, 1, 0, c_R, mk(4,0,0,1,0,0, 0,0,0, 0,0));
      // LW with two wait cycles in MEM
      cyc(0, 1, 0, c_LW, mk(0,1,1,0,1,0, 0,2,0, 0,0));
      cyc(0, 1, 0, c_LW, mk(1,0,0,0,0,0, 0,0,0, 0,0));
      cyc(0, 1, 0, c_LW, mk(2,0,0,0,0,0, 1,1,0, 0,0));
      cyc(0, 0, 0, c_LW, mk(3,0,0,0,1,0, 0,0,0, 0,0));
      cyc(0, 0, 0, c_LW, mk(3,0,0,0,1,0, 0,0,0, 0,0));
      cyc(0, 1, 0, c_LW, mk(3,0,0,0,1,0, 0,0,0, 0,0));
      cyc(0, 1, 0, c_LW, mk(4,0,0,1,0,0, 0,0,1, 0,0));
      // BEQ taken, then not taken
      cyc(0, 1, 1, c_BEQ, mk(0,1,1,0,1,0, 0,2,0, 0,0));
      cyc(0, 1, 1, c_BEQ, mk(1,0,0,0,0,0, 0,0,0, 0,0));
      cyc(0, 1, 1, c_BEQ, mk(2,1,0,0,0,0, 1,0,0, 2,0));
      cyc(0, 1, 0, c_BEQ, mk(0,1,1,0,1,0, 0,2,0, 2,0));
      cyc(0, 1, 0, c_BEQ, mk(1,0,0,0,0,0, 0,0,0, 2,0));
      cyc(0, 1, 0, c_BEQ, mk(2,0,0,0,0,0, 1,0,0, 2,0));
      // SW with one wait cycle in MEM
      cyc(0, 1, 0, c_SW, mk(0,1,1,0,1,0, 0,2,0, 2,0));
      cyc(0, 1, 0, c_SW, mk(1,0,0,0,0,0, 0,0,0, 2,0));
      cyc(0, 1, 0, c_SW, mk(2,0,0,0,0,0, 1,1,0, 1,0));
      cyc(0, 0, 0, c_SW, mk(3,0,0,0,0,1, 0,0,0, 1,0));
      cyc(0, 1, 0, c_SW, mk(3,0,0,0,0,1, 0,0,0, 1,0));
      // JAL
      cyc(0, 1, 0, c_JAL, mk(0,1,1,0,1,0, 0,2,0, 1,0));
      cyc(0, 1, 0, c_JAL, mk(1,0,0,0,0,0, 0,0,0, 1,0));
      cyc(0, 1, 0, c_JAL, mk(2,1,0,0,0,0, 0,1,0, 3,0));
      cyc(0, 1, 0, c_JAL, mk(4,0,0,1,0,0, 0,0,2, 3,0));
      // LUI
      cyc(0, 1, 0, c_LUI, mk(0,1,1,0,1,0, 0,2,0, 3,0));
      cyc(0, 1, 0, c_LUI, mk(1,0,0,0,0,0, 0,0,0, 3,0));
      cyc(0, 1, 0, c_LUI, mk(2,0,0,0,0,0, 2,1,0, 4,0));
      cyc(0, 1, 0, c_LUI, mk(4,0,0,1,0,0, 0,0,0, 4,0));
      // Illegal opcode: sticky flag, ImmSrc retained, back to FETCH
      cyc(0, 1, 0, c_BAD, mk(0,1,1,0,1,0, 0,2,0, 4,0));
      cyc(0, 1, 0, c_BAD, mk(1,0,0,0,0,0, 0,0,0, 4,0));
      cyc(0, 0, 0, c_SW,  mk(0,0,0,0,1,0, 0,2,0, 4,1));
      // SW interrupted by reset in MEM
      cyc(0, 1, 0, c_SW, mk(0,1,1,0,1,0, 0,2,0, 4,1));
      cyc(0, 1, 0, c_SW, mk(1,0,0,0,0,0, 0,0,0, 4,1));
      cyc(0, 1, 0, c_SW, mk(2,0,0,0,0,0, 1,1,0, 1,1));
      mem_ready = 1'b0;
      sb.push_back(mk(3,0,0,0,0,1, 0,0,0, 1,1));
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      sb.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,0));
      -> ev_async;
      @(posedge clk);
      #1;
      cyc(1, 1, 0, c_R, mk(0,0,0,0,0,0, 0,0,0, 0,0));
      cyc(0, 1, 0, c_R, mk(0,0,0,0,0,0, 0,0,0, 0,0));
      cyc(0, 1, 0, c_R, mk(0,1,1,0,1,0, 0,2,0, 0,0));
      cyc(0, 1, 0, c_R, mk(1,0,0,0,0,0, 0,0,0, 0,0));
      @(negedge clk);
      #1;
      n_total++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL drain actual=%0d pending required=0", sb.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
